// File: rtl/execute_iter.sv
// execute_iter: multi-cycle integer execute unit.
//
// Accepts one op per in_valid/in_ready handshake. ADD/SUB/SLT/SLL/SRA go
// straight to DONE. MUL (shift-add) and DIV/REM (restoring, on magnitudes)
// spend WIDTH cycles in ITER, one bit per cycle. The result is held in DONE
// until out_ready. A new op may be accepted on the same edge that the held
// result is consumed.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    op handshake (in_ready is forced low while flush=1)
//   in_op                0 ADD, 1 SUB, 2 SLT, 3 SLL, 4 SRA, 5 MUL, 6 DIV, 7 REM
//   in_a, in_b, in_tag   operands and destination tag
//   flush                kill any in-flight or held op at the next edge
//   out_valid/out_ready  result handshake
//   out_data, out_tag    result and its tag
//   busy                 unit is not idle
//
// State | meaning
// IDLE  | no op held, ready for a new op
// ITER  | iterative op running, counter 0..WIDTH-1
// DONE  | result held on out_data/out_tag, out_valid=1

module execute_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd2;
    localparam logic [2:0] OP_SLL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_REM = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    // MUL: acc = partial product, x = shifted multiplicand, y = shifted multiplier
    // DIV/REM: acc = partial remainder, x = dividend bits in / quotient bits out, y = divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             accept;
    logic             in_is_iter;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] step_acc, step_x, step_y;
    logic [WIDTH-1:0] iter_res;

    assign accept     = in_valid & in_ready;
    assign in_is_iter = (in_op == OP_MUL) | (in_op == OP_DIV) | (in_op == OP_REM);
    assign shamt      = in_b[SH_W-1:0];
    assign a_mag      = in_a[WIDTH-1] ? -in_a : in_a;
    assign b_mag      = in_b[WIDTH-1] ? -in_b : in_b;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) state_d = in_is_iter ? S_ITER : S_DONE;
                end
                S_ITER: begin
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
                S_DONE: begin
                    if (accept)         state_d = in_is_iter ? S_ITER : S_DONE;
                    else if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // ---------------- one iteration step ----------------
    always_comb begin
        rem_sh   = {acc_q, x_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, y_q};
        step_y   = y_q;
        if (op_q == OP_MUL) begin
            step_acc = acc_q + (y_q[0] ? x_q : '0);
            step_x   = x_q << 1;
            step_y   = y_q >> 1;
        end else if (!rem_diff[WIDTH]) begin
            step_acc = rem_diff[WIDTH-1:0];
            step_x   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_sh[WIDTH-1:0];
            step_x   = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fixup applied to the final step's values on the way into DONE.
    // Divide by zero only needs the quotient overridden: restoring division
    // by zero leaves |a| as remainder, which the dividend-sign fixup maps to a.
    always_comb begin
        case (op_q)
            OP_MUL:  iter_res = step_acc;
            OP_DIV:  iter_res = dz_q ? '1 : (q_neg_q ? -step_x : step_x);
            default: iter_res = r_neg_q ? -step_acc : step_acc;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;

        if (accept) begin
            op_d      = in_op;
            out_tag_d = in_tag;
            if (!in_is_iter) begin
                out_data_d = alu_res;
            end else begin
                cnt_d = '0;
                acc_d = '0;
                if (in_op == OP_MUL) begin
                    x_d = in_a;
                    y_d = in_b;
                end else begin
                    x_d     = a_mag;
                    y_d     = b_mag;
                    q_neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                    r_neg_d = in_a[WIDTH-1];
                    dz_d    = (in_b == '0);
                end
            end
        end else if ((state_q == S_ITER) && !flush) begin
            acc_d = step_acc;
            x_d   = step_x;
            y_d   = step_y;
            if (cnt_q == CNT_LAST) out_data_d = iter_res;
            else                   cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;

endmodule

// File: tb/tb_execute_iter.sv
// Testbench for execute_iter (WIDTH=32, TAG_W=5). Expected results come from a
// behavioural model and travel through a scoreboard queue from accept to output.

module tb_execute_iter;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          busy;

    execute_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r[0] = ($signed(a) < $signed(b));
            3'd3: r = a << b[4:0];
            3'd4: r = $signed(a) >>> b[4:0];
            3'd5: r = a * b;
            3'd6: begin
                if (b == '0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            default: begin
                if (b == '0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
        endcase
        return r;
    endfunction

    // Output side pops/compares, input side pushes; both sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (in_valid && in_ready && !flush) begin
                e.data = model(in_op, in_a, in_b);
                e.tag  = in_tag;
                sb.push_back(e);
            end
        end
    end

    // Offer an op until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, output int waited);
        bit got;
        got      = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) check("send_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edge (counted from the accept edge) at which the result is transferred.
    task automatic latency(output int edge_n, output bit rdy_seen);
        int n;
        rdy_seen = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (out_valid) break;
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        edge_n = n + 1;
    endtask

    task automatic drain(input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !out_valid && !busy) begin
                done = 1'b1;
                break;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        if (!done) check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'(0));
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t vecs[10];
    logic [W-1:0] vals[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int w, n;
        bit r;
        logic [W-1:0]  d0;
        logic [TW-1:0] t0;
        bit stable;

        vecs[0] = '{3'd6, 32'd5,          32'd0};
        vecs[1] = '{3'd7, 32'd5,          32'd0};
        vecs[2] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF};
        vecs[3] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF};
        vecs[4] = '{3'd5, 32'hFFFF_FFFF,  32'd3};
        vecs[5] = '{3'd5, 32'h0001_0000,  32'h0001_0000};
        vecs[6] = '{3'd4, 32'h8000_0000,  32'd4};
        vecs[7] = '{3'd2, 32'hFFFF_FFFF,  32'd1};
        vecs[8] = '{3'd3, 32'h0000_0001,  32'd31};
        vecs[9] = '{3'd7, 32'hFFFF_FFF9,  32'hFFFF_FFFE};

        vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFF9,
                 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // ADD then back-to-back SUB with no bubble
        send(3'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, w);
        check("add_valid_edge1", 64'(out_valid), 64'(1));
        send(3'd1, 32'd5, 32'd7, 5'd4, w);
        check("b2b_wait", 64'(w), 64'(0));
        check("b2b_valid", 64'(out_valid), 64'(1));
        drain(1'b0);

        // DIV / REM latency and in_ready low throughout ITER
        send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, w);
        latency(n, r);
        check("div_latency", 64'(n), 64'(W + 1));
        check("div_iter_ready", 64'(r), 64'(0));
        drain(1'b0);
        send(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, w);
        latency(n, r);
        check("rem_latency", 64'(n), 64'(W + 1));
        check("rem_iter_ready", 64'(r), 64'(0));
        drain(1'b0);

        // Boundary vectors: divide by zero, overflow, MUL wrap, SRA, etc.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, TW'(i + 16), w);
            drain(1'b0);
        end

        // Backpressure: result held stable 10 cycles, then handoff on same edge
        out_ready = 1'b0;
        send(3'd0, 32'd10, 32'd20, 5'd9, w);
        check("bp_valid", 64'(out_valid), 64'(1));
        d0     = out_data;
        t0     = out_tag;
        stable = 1'b1;
        r      = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_data !== d0 || out_tag !== t0) stable = 1'b0;
            if (in_ready) r = 1'b1;
        end
        check("bp_stable", 64'(stable), 64'(1));
        check("bp_in_ready", 64'(r), 64'(0));
        out_ready = 1'b1;
        send(3'd1, 32'd100, 32'd1, 5'd10, w);
        check("bp_handoff_wait", 64'(w), 64'(0));
        drain(1'b0);

        // flush at ITER cycle 10 discards the op
        send(3'd6, 32'd1000, 32'd7, 5'd11, w);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        sb.delete();
        quiet("flush_quiet", W + 4);

        // Reset mid-ITER aborts immediately
        send(3'd5, 32'd123, 32'd456, 5'd12, w);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        quiet("midrst_quiet", W + 4);
        send(3'd0, 32'd2, 32'd3, 5'd13, w);
        check("post_rst_add_valid", 64'(out_valid), 64'(1));
        drain(1'b0);

        // flush with in_valid in IDLE: not accepted
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_tag   = 5'd14;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'(0));
        check("flush_idle_valid", 64'(out_valid), 64'(0));

        // Random ops with random consumer backpressure
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 1) != 0) ? vals[$urandom_range(0, 7)] : W'($urandom());
            b = ($urandom_range(0, 1) != 0) ? vals[$urandom_range(0, 7)] : W'($urandom());
            send(3'($urandom_range(0, 7)), a, b, TW'($urandom_range(0, 31)), w);
            drain(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execute_iter.md
Name: execute_iter

Overview:
- Parametrised multi-cycle successor to the single-cycle integer execute path.
- Accepts one integer op per handshake and completes it in one cycle or iteratively. Iterative ops are an iterative multiply and a signed divide/remainder, replacing the constant-only DIV10/DIV2.
- Results return with the destination tag under valid/ready backpressure.
- Sits between decode/issue and writeback. The core stalls on in_ready=0.

Parameters:
WIDTH, 32, operand/result width (>=4)
TAG_W, 5, destination register tag width
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  op offered
in_ready  out  1  unit can accept op this cycle
in_op  in  3  0 ADD, 1 SUB, 2 SLT, 3 SLL, 4 SRA, 5 MUL, 6 DIV, 7 REM
in_a  in  WIDTH  operand s (signed where relevant)
in_b  in  WIDTH  operand t (shift amount = in_b[$clog2(WIDTH)-1:0])
in_tag  in  TAG_W  destination tag
flush  in  1  kill in-flight op (branch mispredict/exception)
out_valid  out  1  result held
out_ready  in  1  consumer takes result
out_data  out  WIDTH  result
out_tag  out  TAG_W  tag of result
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE; out_valid=0; out_data=0; out_tag=0; counter=0; busy=0; all datapath registers 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Ready is never asserted while flush=1.
- Accept means in_valid & in_ready & ~flush at a rising edge. The accepting edge is called edge 0.
- States and transitions:
  - IDLE -> DONE on accept of ops 0-4.
  - IDLE -> ITER on accept of ops 5-7.
  - ITER -> DONE when the counter reaches WIDTH-1.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE or ITER on out_ready with a new accept.
- Latency: ops 0-4 give out_valid=1 after edge 1. Ops 5-7 give out_valid=1 after edge WIDTH+1, i.e. WIDTH cycles in ITER.
- out_valid is asserted exactly in DONE. out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT gives 1 if $signed(a) < $signed(b), else 0.
  - SLL is a logical left shift. SRA is an arithmetic right shift.
  - MUL uses shift-add, one bit per cycle. Result is the low WIDTH bits, identical for signed and unsigned.
- DIV/REM:
  - Operands are converted to magnitudes at accept, then restoring division runs one bit per cycle.
  - Sign fixup at the transition into DONE:
    - quotient is negative iff signs differ;
    - remainder takes the sign of the dividend.
  - Divide by zero: DIV = all ones; REM = in_a.
  - Overflow (a = -2^(WIDTH-1), b = -1): DIV = -2^(WIDTH-1); REM = 0.
- Counter runs 0..WIDTH-1 in ITER and clears on entry to ITER.
- flush (synchronous):
  - At the next edge, state=IDLE and out_valid=0 regardless of state.
  - It discards an unconsumed DONE result.
  - It has priority over accept in the same cycle.
  - out_data and out_tag are not cleared.
- Simultaneous out_ready and accept in DONE: the old result is consumed and the new op is accepted on the same edge. Zero-bubble throughput for ops 0-4.
- Reset asserted mid-ITER aborts immediately. The first accept after deassertion behaves as from IDLE.

Test Plan:
- ADD 0x7FFFFFFF+1, tag 3, out_ready=1 -> out_valid after edge 1, data 0x80000000, tag 3. Back-to-back SUB 5-7 next cycle -> 0xFFFFFFFE, no bubble.
- DIV -7/2, REM -7/2 (WIDTH=32) -> 0xFFFFFFFD and 0xFFFFFFFF, each out_valid exactly 33 edges after accept. in_ready=0 throughout ITER.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0.
- MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD. MUL 0x10000*0x10000 -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- Backpressure: out_ready=0 for 10 cycles after DONE -> out_data/out_tag stable, in_ready=0. Release with a new in_valid -> handoff on the same edge.
- flush at ITER cycle 10, then reset pulse mid-ITER on a second op -> out_valid never rises, state IDLE, next ADD completes normally after 1 cycle. flush with in_valid=1 in IDLE -> op not accepted.
